// File: rtl/neg_abs_serial.sv
// Digit-serial pass / negate / absolute-value unit: one DIGIT-bit slice per cycle, LSB first.
// Two's-complement negation is done as invert-and-add-one, with the +1 injected as the initial carry.
module neg_abs_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST     = CW'(N - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             invert_q;
    logic             invert_d;
    logic             carry_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] digit;
    logic [DIGIT:0]   sum;

    always_comb begin
        digit    = '0;
        result_d = result_q;
        for (int d = 0; d < N; d++) begin
            if (cnt_q == CW'(d)) digit = operand_q[d*DIGIT +: DIGIT];
        end
        sum = {1'b0, digit ^ {DIGIT{invert_q}}} + {{DIGIT{1'b0}}, carry_q};
        for (int d = 0; d < N; d++) begin
            if (cnt_q == CW'(d)) result_d[d*DIGIT +: DIGIT] = sum[DIGIT-1:0];
        end
        // mode 11 is reserved and behaves as pass
        invert_d = (mode == 2'b01) || ((mode == 2'b10) && in_data[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            operand_q <= '0;
            result_q  <= '0;
            invert_q  <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        operand_q <= in_data;
                        invert_q  <= invert_d;
                        carry_q   <= invert_d;
                        ovf_q     <= invert_d && (in_data == MOST_NEG);
                        result_q  <= '0;
                        cnt_q     <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // carry out of the top digit is dropped: result is modulo 2^WIDTH
                    result_q <= result_d;
                    carry_q  <= sum[DIGIT];
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = result_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_neg_abs_serial.sv
// Testbench for neg_abs_serial: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_neg_abs_serial;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rstN;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic [1:0]       mode;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;
    logic             outOvf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    neg_abs_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .mode      (mode),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_ovf   (outOvf)
    );

    // Reference: {ovf, result} from ordinary two's-complement arithmetic
    function automatic logic [WIDTH:0] refModel(input logic [WIDTH-1:0] d, input logic [1:0] m);
        logic             neg;
        logic [WIDTH-1:0] r;
        neg = (m == 2'b01) || ((m == 2'b10) && ($signed(d) < 0));
        r   = neg ? (WIDTH'(0) - d) : d;
        return {neg && (d == {1'b1, {(WIDTH-1){1'b0}}}), r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One full operation: accept, latency, result, optional backpressure, release
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic [1:0] m, input int holdCycles);
        logic [WIDTH:0]   expv;
        logic [WIDTH-1:0] held;
        int               edges;
        expv = refModel(data, m);
        checkOutput("idle_ready", inReady, 1);
        inValid = 1'b1;
        inData  = data;
        mode    = m;
        @(posedge clk); #1;
        inValid = 1'b0;
        inData  = WIDTH'($urandom);
        mode    = 2'($urandom);
        edges   = 0;
        while (outValid !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("latency", edges, N);
        checkOutput("data", outData, expv[WIDTH-1:0]);
        checkOutput("ovf", outOvf, expv[WIDTH]);
        checkOutput("busy_ready", inReady, 0);
        held = outData;
        for (int i = 0; i < holdCycles; i++) begin
            inValid = 1'b1;
            inData  = WIDTH'($urandom);
            mode    = 2'($urandom);
            @(posedge clk); #1;
            inValid = 1'b0;
            checkOutput("hold_valid", outValid, 1);
            checkOutput("hold_data", outData, held);
            checkOutput("hold_ovf", outOvf, expv[WIDTH]);
            checkOutput("hold_ready", inReady, 0);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("release_valid", outValid, 0);
        checkOutput("release_ready", inReady, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stray;
        logic [WIDTH-1:0] rdata;
        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        mode     = 2'b00;
        outReady = 1'b0;
        #1;
        checkOutput("reset_valid", outValid, 0);
        checkOutput("reset_ready", inReady, 1);
        checkOutput("reset_data", outData, 0);
        checkOutput("reset_ovf", outOvf, 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;

        // accept right after reset release, on the very first edge
        applyStimulus(16'hFFFB, 2'b10, 0);
        applyStimulus(16'h0000, 2'b01, 0);
        applyStimulus(16'h0001, 2'b01, 0);
        applyStimulus(16'h8000, 2'b10, 0);
        applyStimulus(16'h8000, 2'b00, 0);
        applyStimulus(16'h8000, 2'b01, 1);
        applyStimulus(16'h8123, 2'b11, 0);
        applyStimulus(16'h1234, 2'b10, 0);
        applyStimulus(16'hFFFB, 2'b10, 3);

        // abort an operation with reset two cycles after accept
        inValid = 1'b1;
        inData  = 16'h1234;
        mode    = 2'b01;
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        checkOutput("abort_valid", outValid, 0);
        checkOutput("abort_ready", inReady, 1);
        checkOutput("abort_data", outData, 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        stray = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (outValid === 1'b1) stray++;
        end
        checkOutput("abort_no_result", stray, 0);
        applyStimulus(16'h0003, 2'b01, 0);

        for (int i = 0; i < 40; i++) begin
            rdata = ($urandom_range(0, 7) == 0) ? 16'h8000 : WIDTH'($urandom);
            applyStimulus(rdata, 2'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
